// File: rtl/dmem_pipe.sv
// Handshaked load/store data memory: one request at a time, synchronous RAM
// with byte enables, fault/misalignment reporting and sticky tohost capture.
// Optional macro DMEM_PIPE_MISALIGN_EN enables split (two-beat) misaligned accesses.
module dmem_pipe #(
    parameter int              XLEN        = 64,
    parameter int              DEPTH_BYTES = 16384,
    parameter logic [XLEN-1:0] BASE_ADDR   = 'h80000000,
    parameter logic [XLEN-1:0] TOHOST_ADDR = 'h80001000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_exc,
    output logic [3:0]      rsp_exc_code,
    output logic [XLEN-1:0] rsp_exc_val,
    output logic            tohost_hit,
    output logic [XLEN-1:0] tohost_data
);
    localparam int LANES = XLEN / 8;
    localparam int LW    = $clog2(LANES);
    localparam int WORDS = DEPTH_BYTES / LANES;
    localparam int AW    = $clog2(WORDS);
    localparam logic [XLEN:0] DEPTH_X = (XLEN+1)'(DEPTH_BYTES);
`ifdef DMEM_PIPE_MISALIGN_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;
    state_t state, state_nxt;

    logic            we_q, uns_q;
    logic [XLEN-1:0] addr_q, wdata_q, rd_lo;
    logic [1:0]      size_q;
    logic [XLEN-1:0] mem [WORDS];

    logic [XLEN:0]         off_ext, end_ext;
    logic [3:0]            nbytes, exc_code_nx;
    logic [2:0]            amask;
    logic [4:0]            lane_end;
    logic                  fault, misal, exc, crossing, sign;
    logic [LW-1:0]         lane;
    logic [AW-1:0]         widx, widx_nx;
    logic [2*LANES-1:0]    be_full;
    logic [2*XLEN-1:0]     wide_data, rd_pair, rd_shift;
    logic [XLEN-1:0]       ld_raw, ld_ext;
    logic                  unused_bits;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    // Address decode runs off the captured request; widened by one bit so
    // offset + nbytes can never wrap.
    always_comb begin
        nbytes      = 4'd1 << size_q;
        off_ext     = {1'b0, addr_q} - {1'b0, BASE_ADDR};
        end_ext     = off_ext + {{(XLEN-3){1'b0}}, nbytes};
        fault       = (addr_q < BASE_ADDR) || (end_ext > DEPTH_X) ||
                      ((XLEN == 32) && (size_q == 2'd3));
        amask       = 3'(nbytes - 4'd1);
        misal       = |(addr_q[2:0] & amask);
        exc         = fault || (misal && !MIS_EN);
        lane        = off_ext[LW-1:0];
        widx        = off_ext[LW +: AW];
        widx_nx     = widx + AW'(1);
        lane_end    = 5'(lane) + 5'(nbytes);
        crossing    = MIS_EN && !exc && (lane_end > 5'(LANES));
        exc_code_nx = fault ? (we_q ? 4'd7 : 4'd5) : (we_q ? 4'd6 : 4'd4);
        be_full     = (2*LANES)'((16'd1 << nbytes) - 16'd1) << lane;
        wide_data   = {{XLEN{1'b0}}, wdata_q} << {lane, 3'b000};
    end

    // Load path: beat-1 reads are concatenated above the saved beat-0 word.
    always_comb begin
        rd_pair  = (state == BEAT1) ? {mem[widx_nx], rd_lo} : {{XLEN{1'b0}}, mem[widx]};
        rd_shift = rd_pair >> {lane, 3'b000};
        ld_raw   = rd_shift[XLEN-1:0];
        sign     = 1'b0;
        for (int i = 0; i < XLEN; i++)
            if (i == 8*int'(nbytes) - 1) sign = ld_raw[i];
        ld_ext = ld_raw;
        for (int i = 0; i < XLEN; i++)
            if (i >= 8*int'(nbytes)) ld_ext[i] = sign & ~uns_q;
    end

    assign unused_bits = ^{off_ext[XLEN:LW+AW], rd_shift[2*XLEN-1:XLEN]};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = BEAT0;
            BEAT0:   state_nxt = crossing ? BEAT1 : RESP;
            BEAT1:   state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // RAM has no reset; an async reset forces IDLE so a pending beat-1 write is dropped.
    always_ff @(posedge clk) begin
        if (state == BEAT0 && we_q && !exc)
            for (int i = 0; i < LANES; i++)
                if (be_full[i]) mem[widx][8*i +: 8] <= wide_data[8*i +: 8];
        if (state == BEAT1 && we_q)
            for (int i = 0; i < LANES; i++)
                if (be_full[LANES+i]) mem[widx_nx][8*i +: 8] <= wide_data[XLEN+8*i +: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q         <= 1'b0;
            uns_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            size_q       <= '0;
            rd_lo        <= '0;
            rsp_rdata    <= '0;
            rsp_exc      <= 1'b0;
            rsp_exc_code <= '0;
            rsp_exc_val  <= '0;
            tohost_hit   <= 1'b0;
            tohost_data  <= '0;
        end else begin
            if (req_valid && req_ready) begin
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                size_q  <= req_size;
            end
            if (state == BEAT0) begin
                rd_lo        <= mem[widx];
                rsp_exc      <= exc;
                rsp_exc_code <= exc ? exc_code_nx : 4'd0;
                rsp_exc_val  <= exc ? addr_q : '0;
                if (!crossing) rsp_rdata <= (we_q || exc) ? '0 : ld_ext;
                if (we_q && !exc && addr_q == TOHOST_ADDR) begin
                    tohost_hit <= 1'b1;
                    if (!tohost_hit) tohost_data <= wdata_q;
                end
            end
            if (state == BEAT1) rsp_rdata <= we_q ? '0 : ld_ext;
        end
    end
endmodule

// File: tb/tb_dmem_pipe.sv
// Randomized bench for dmem_pipe against a byte-array reference model,
// plus the directed load/store, fault, hold, tohost and mid-op reset cases.
module tb_dmem_pipe;
    localparam logic [63:0] BASE   = 64'h80000000;
    localparam logic [63:0] TOHOST = 64'h80001000;
    localparam int          DEPTH  = 16384;
`ifdef DMEM_PIPE_MISALIGN_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0, rsp_ready = 1'b0;
    logic [63:0] req_addr = '0, req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic        req_ready, rsp_valid, rsp_exc, tohost_hit;
    logic [63:0] rsp_rdata, rsp_exc_val, tohost_data;
    logic [3:0]  rsp_exc_code;

    dmem_pipe #(.XLEN(64), .DEPTH_BYTES(DEPTH), .BASE_ADDR(BASE), .TOHOST_ADDR(TOHOST)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_exc(rsp_exc), .rsp_exc_code(rsp_exc_code),
        .rsp_exc_val(rsp_exc_val), .tohost_hit(tohost_hit), .tohost_data(tohost_data)
    );

    always #5 clk = ~clk;

    int          n_chk = 0, n_pass = 0;
    logic [7:0]  ref_mem [DEPTH];
    logic        m_hit = 1'b0;
    logic [63:0] m_data = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference: flat byte array, whole-access semantics; beats only matter for latency.
    task automatic model(input bit we, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [1:0] size, input bit uns,
                         output logic [63:0] rdata, output logic exc, output logic [3:0] code,
                         output logic [63:0] val, output int lat);
        int          nb;
        logic [64:0] off;
        bit          fault, mis;
        nb    = 1 << size;
        off   = {1'b0, addr} - {1'b0, BASE};
        fault = (addr < BASE) || (off + 65'(nb) > 65'(DEPTH));
        mis   = (addr % 64'(nb)) != 0;
        rdata = '0; exc = 1'b0; code = '0; val = '0; lat = 2;
        if (fault) begin
            exc = 1'b1; code = we ? 4'd7 : 4'd5; val = addr;
        end else if (mis && !MIS) begin
            exc = 1'b1; code = we ? 4'd6 : 4'd4; val = addr;
        end else begin
            if ((int'(off) % 8) + nb > 8) lat = 3;
            if (we) begin
                for (int i = 0; i < nb; i++) ref_mem[int'(off) + i] = wdata[8*i +: 8];
                if (addr == TOHOST) begin
                    if (!m_hit) m_data = wdata;
                    m_hit = 1'b1;
                end
            end else begin
                for (int i = 0; i < nb; i++) rdata[8*i +: 8] = ref_mem[int'(off) + i];
                if (!uns && size != 2'd3 && rdata[8*nb-1])
                    for (int i = 8*nb; i < 64; i++) rdata[i] = 1'b1;
            end
        end
    endtask

    task automatic run_req(input bit we, input logic [63:0] addr, input logic [63:0] wdata,
                           input logic [1:0] size, input bit uns, input int hold,
                           output logic [63:0] got);
        logic [63:0] e_rdata, e_val;
        logic        e_exc;
        logic [3:0]  e_code;
        int          e_lat, n;
        model(we, addr, wdata, size, uns, e_rdata, e_exc, e_code, e_val, e_lat);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        req_size = size; req_unsigned = uns;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        chk("req_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 20);
        chk("latency", 64'(n), 64'(e_lat));
        chk("exc", 64'(rsp_exc), 64'(e_exc));
        chk("exc_code", 64'(rsp_exc_code), 64'(e_code));
        chk("exc_val", rsp_exc_val, e_val);
        chk("rdata", rsp_rdata, e_rdata);
        got = rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 64'(rsp_valid), 64'd1);
            chk("hold_rdata", rsp_rdata, e_rdata);
            chk("hold_exc_val", rsp_exc_val, e_val);
            chk("hold_req_ready", 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic check_rst(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_rdata"}, rsp_rdata, 64'd0);
        chk({tag, "_exc"}, 64'(rsp_exc), 64'd0);
        chk({tag, "_exc_code"}, 64'(rsp_exc_code), 64'd0);
        chk({tag, "_exc_val"}, rsp_exc_val, 64'd0);
        chk({tag, "_tohost_hit"}, 64'(tohost_hit), 64'd0);
        chk({tag, "_tohost_data"}, tohost_data, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] got, a;
        int          r;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
        #1 check_rst("rst0");
        @(negedge clk); rst_n = 1'b1;

        // Bring RAM to a known state, then reset so tohost starts clear.
        for (int i = 0; i < DEPTH / 8; i++)
            run_req(1'b1, BASE + 64'(8*i), 64'd0, 2'd3, 1'b0, 0, got);
        @(negedge clk); rst_n = 1'b0;
        m_hit = 1'b0; m_data = '0;
        #1 check_rst("rst1");
        @(negedge clk); rst_n = 1'b1;

        run_req(1'b1, 64'h80002000, 64'h1122334455667788, 2'd3, 1'b0, 0, got);
        run_req(1'b0, 64'h80002000, 64'd0, 2'd0, 1'b1, 0, got); chk("lbu_const", got, 64'h88);
        run_req(1'b0, 64'h80002000, 64'd0, 2'd1, 1'b0, 0, got); chk("lh_const", got, 64'h7788);
        run_req(1'b0, 64'h80002004, 64'd0, 2'd2, 1'b1, 0, got); chk("lwu_const", got, 64'h11223344);
        run_req(1'b0, 64'h80002000, 64'd0, 2'd3, 1'b0, 0, got); chk("ld_const", got, 64'h1122334455667788);

        run_req(1'b1, 64'h80002010, 64'h80, 2'd0, 1'b0, 0, got);
        run_req(1'b0, 64'h80002010, 64'd0, 2'd0, 1'b0, 0, got); chk("lb_const", got, 64'hFFFFFFFFFFFFFF80);
        run_req(1'b0, 64'h80002010, 64'd0, 2'd0, 1'b1, 0, got); chk("lbu80_const", got, 64'h80);

        run_req(1'b1, 64'h80003FFE, 64'hDEADBEEF, 2'd2, 1'b0, 0, got);
        run_req(1'b0, 64'h80003FF8, 64'd0, 2'd3, 1'b0, 0, got); chk("edge_unchanged", got, 64'd0);
        run_req(1'b0, 64'h7FFFFFF8, 64'd0, 2'd3, 1'b0, 0, got);

        run_req(1'b1, 64'h80002008, 64'hAABBCCDDEEFF0011, 2'd3, 1'b0, 0, got);
        run_req(1'b0, 64'h80002006, 64'd0, 2'd2, 1'b0, 0, got);
`ifdef DMEM_PIPE_MISALIGN_EN
        chk("lw_mis_const", got, 64'h00111122);
`else
        chk("lw_mis_const", got, 64'd0);
`endif

        run_req(1'b0, 64'h80002000, 64'd0, 2'd3, 1'b0, 5, got);

        run_req(1'b1, TOHOST, 64'h1, 2'd3, 1'b0, 0, got);
        run_req(1'b1, TOHOST, 64'h2, 2'd3, 1'b0, 0, got);
        @(negedge clk);
        chk("tohost_hit", 64'(tohost_hit), 64'(m_hit));
        chk("tohost_data", tohost_data, 64'h1);

        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       a = 64'h80002000 + 64'($urandom_range(0, 63));
            else if (r == 7) a = 64'h80003FF0 + 64'($urandom_range(0, 15));
            else if (r == 8) a = 64'h7FFFFFF0 + 64'($urandom_range(0, 15));
            else             a = BASE + 64'($urandom_range(0, 15));
            run_req(1'($urandom_range(0, 1)), a, {$urandom, $urandom},
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0, got);
        end
        chk("tohost_data_sticky", tohost_data, m_data);

        // Reset mid-store: split store dropped after beat 0 (or aligned store before commit).
        @(negedge clk);
`ifdef DMEM_PIPE_MISALIGN_EN
        a = 64'h80002024;
`else
        a = 64'h80002020;
`endif
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = 64'h0102030405060708;
        req_size = 2'd3; req_unsigned = 1'b0;
        chk("rstop_req_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
`ifdef DMEM_PIPE_MISALIGN_EN
        @(negedge clk);
        for (int i = 0; i < 4; i++) ref_mem[int'(a - BASE) + i] = req_wdata[8*i +: 8];
`endif
        rst_n = 1'b0;
        m_hit = 1'b0; m_data = '0;
        #1 check_rst("rst2");
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst2_no_rsp", 64'(rsp_valid), 64'd0);
        end
        run_req(1'b0, 64'h80002020, 64'd0, 2'd3, 1'b0, 0, got);
        run_req(1'b0, 64'h80002028, 64'd0, 2'd3, 1'b0, 0, got);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
